dla_platform_hw_timer_csr: RTL and testbench

- Host-facing CSR front end for the platform hardware timer (clock-frequency estimator).
- Decodes Avalon-MM register accesses and drives one-cycle start/stop pulses into the timer.
- Consumes the timer's free-running counter and snapshots it coherently for 32-bit host reads.
- Provides an optional auto-stop window, so the host can measure exactly N cycles without software timing jitter.

---
 rtl/dla_platform_hw_timer_csr.sv | 183 ++++++++++++++++++
 tb/tb_dla_platform_hw_timer_csr.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dla_platform_hw_timer_csr.sv
// dla_platform_hw_timer_csr
//   Host-facing CSR front end for the platform hardware timer. It decodes Avalon-MM
//   accesses and issues one-cycle start/stop pulses to the timer. It snapshots the
//   timer count for coherent 32-bit reads. An optional auto-stop window lets the host
//   measure exactly N cycles.
//
// Ports:
//   clk                  timer clock
//   i_resetn_async       async active-low reset (synchronized internally)
//   i_csr_address        CSR word address
//   i_csr_read/_write    access strobes (never stalled)
//   i_csr_writedata      write data
//   o_csr_readdata       read data, valid with o_csr_readdatavalid (1-cycle latency)
//   o_csr_readdatavalid  read response strobe
//   o_csr_waitrequest    tied 0
//   o_start / o_stop     one-cycle control pulses to the timer
//   i_counter            timer count value
//
// Register map (word address):
//   0 CONTROL   W: bit0 start, bit1 stop (stop wins)    R: {31'b0, running}
//   1 STATUS    R: {auto_done, snap_valid, running}     W: bit2 clears auto_done
//   2 COUNT_LO  R: capture i_counter, return snapshot[31:0]
//   3 COUNT_HI  R: snapshot[63:32] (no recapture)
//   4 AUTO_STOP R/W: N, 0 disables
module dla_platform_hw_timer_csr #(
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     i_resetn_async,
    input  logic [ADDR_WIDTH-1:0]    i_csr_address,
    input  logic                     i_csr_read,
    input  logic                     i_csr_write,
    input  logic [31:0]              i_csr_writedata,
    output logic [31:0]              o_csr_readdata,
    output logic                     o_csr_readdatavalid,
    output logic                     o_csr_waitrequest,
    output logic                     o_start,
    output logic                     o_stop,
    input  logic [COUNTER_WIDTH-1:0] i_counter
);

    localparam logic [ADDR_WIDTH-1:0] AddrControl  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] AddrStatus   = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] AddrCountLo  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] AddrCountHi  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] AddrAutoStop = ADDR_WIDTH'(4);

    // Reset synchronizer: asserts asynchronously, releases on the second clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge i_resetn_async) begin
        if (!i_resetn_async) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        running_q, running_d;
    logic        snap_valid_q, snap_valid_d;
    logic        auto_done_q, auto_done_d;
    logic [63:0] snap_q, snap_d;
    logic [31:0] auto_n_q, auto_n_d;
    logic        armed_q, armed_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q;

    logic        wr_ctrl, wr_status, wr_auto, rd_lo;
    logic        host_start, host_stop;
    logic        eff_armed, auto_fire;
    logic [31:0] eff_cnt;
    logic [63:0] counter_ext;

    assign counter_ext = 64'(i_counter);

    assign wr_ctrl    = i_csr_write && (i_csr_address == AddrControl);
    assign wr_status  = i_csr_write && (i_csr_address == AddrStatus);
    assign wr_auto    = i_csr_write && (i_csr_address == AddrAutoStop);
    assign rd_lo      = i_csr_read && (i_csr_address == AddrCountLo);
    assign host_start = wr_ctrl && i_csr_writedata[0] && !i_csr_writedata[1];
    assign host_stop  = wr_ctrl && i_csr_writedata[1];

    // The cycle carrying o_start acts as countdown step 0 loaded with N, so the stop
    // pulse (registered) lands exactly N cycles after the start pulse; N=1 fires at once.
    assign eff_armed = start_q ? (auto_n_q != 32'd0) : armed_q;
    assign eff_cnt   = start_q ? auto_n_q : cnt_q;
    // A host start/stop accepted this cycle takes over: stop cancels, start re-arms.
    assign auto_fire = eff_armed && (eff_cnt == 32'd1) && !host_start && !host_stop;

    always_comb begin
        start_d      = host_start;
        stop_d       = host_stop || auto_fire;
        running_d    = running_q;
        snap_valid_d = snap_valid_q;
        snap_d       = snap_q;
        auto_done_d  = auto_done_q;
        auto_n_d     = auto_n_q;
        armed_d      = eff_armed;
        cnt_d        = eff_cnt - 32'd1;
        rdata_d      = 32'd0;

        if (start_q) begin
            running_d = 1'b1;
        end else if (stop_q) begin
            running_d = 1'b0;
        end

        if (host_stop || host_start || auto_fire) begin
            armed_d = 1'b0;
        end

        if (auto_fire) begin
            auto_done_d = 1'b1;
        end else if (wr_status && i_csr_writedata[2]) begin
            auto_done_d = 1'b0;
        end

        if (rd_lo) begin
            snap_d       = counter_ext;
            snap_valid_d = 1'b1;
        end else if (start_q) begin
            snap_valid_d = 1'b0;
        end

        if (wr_auto) begin
            auto_n_d = i_csr_writedata;
        end

        // Read mux uses pre-write state, except COUNT_LO which returns the fresh capture.
        if (i_csr_read) begin
            case (i_csr_address)
                AddrControl:  rdata_d = {31'd0, running_q};
                AddrStatus:   rdata_d = {29'd0, auto_done_q, snap_valid_q, running_q};
                AddrCountLo:  rdata_d = counter_ext[31:0];
                AddrCountHi:  rdata_d = snap_q[63:32];
                AddrAutoStop: rdata_d = auto_n_q;
                default:      rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q      <= 1'b0;
            stop_q       <= 1'b0;
            running_q    <= 1'b0;
            snap_valid_q <= 1'b0;
            auto_done_q  <= 1'b0;
            snap_q       <= 64'd0;
            auto_n_q     <= 32'd0;
            armed_q      <= 1'b0;
            cnt_q        <= 32'd0;
            rdata_q      <= 32'd0;
            rvalid_q     <= 1'b0;
        end else begin
            start_q      <= start_d;
            stop_q       <= stop_d;
            running_q    <= running_d;
            snap_valid_q <= snap_valid_d;
            auto_done_q  <= auto_done_d;
            snap_q       <= snap_d;
            auto_n_q     <= auto_n_d;
            armed_q      <= armed_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= i_csr_read;
        end
    end

    assign o_csr_readdata      = rdata_q;
    assign o_csr_readdatavalid = rvalid_q;
    assign o_csr_waitrequest   = 1'b0;
    assign o_start             = start_q;
    assign o_stop              = stop_q;

endmodule

// File: tb/tb_dla_platform_hw_timer_csr.sv
// Bench for dla_platform_hw_timer_csr with a 64-bit counter and a simple timer model.
module tb_dla_platform_hw_timer_csr;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  addr;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid, waitreq, start_p, stop_p;
    logic [63:0] counter, tcnt, force_val;
    logic        trun, force_en;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cnt = 0, stop_cnt = 0, start_cyc = 0, stop_cyc = 0;
    int wreq_seen = 0;

    logic [31:0] exp_q[$];
    int          due_q[$];

    always #5 clk = ~clk;

    assign counter = force_en ? force_val : tcnt;

    dla_platform_hw_timer_csr #(
        .COUNTER_WIDTH(64),
        .ADDR_WIDTH   (4)
    ) dut (
        .clk                (clk),
        .i_resetn_async     (resetn),
        .i_csr_address      (addr),
        .i_csr_read         (rd),
        .i_csr_write        (wr),
        .i_csr_writedata    (wdata),
        .o_csr_readdata     (rdata),
        .o_csr_readdatavalid(rvalid),
        .o_csr_waitrequest  (waitreq),
        .o_start            (start_p),
        .o_stop             (stop_p),
        .i_counter          (counter)
    );

    // Timer model: counts every cycle from the start-pulse cycle up to (not incl.) the stop.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt <= 64'd0;
            trun <= 1'b0;
        end else if (start_p) begin
            tcnt <= 64'd1;
            trun <= 1'b1;
        end else if (stop_p) begin
            trun <= 1'b0;
        end else if (trun) begin
            tcnt <= tcnt + 64'd1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (waitreq !== 1'b0) wreq_seen++;
        if (start_p) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (stop_p) begin
            stop_cnt++;
            stop_cyc = cyc;
        end
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 64'd1, 64'd0);
            end else begin
                check("rdata", 64'(rdata), 64'(exp_q.pop_front()));
                check("rlatency", 64'(cyc), 64'(due_q.pop_front()));
            end
        end
    end

    // Each access task is entered at a negedge and consumes exactly one cycle.
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
        addr = a; wr = 1'b1; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [31:0] exp);
        addr = a; rd = 1'b1;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 1);
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic rdwr_reg(input logic [3:0] a, input logic [31:0] d, input logic [31:0] exp);
        addr = a; rd = 1'b1; wr = 1'b1; wdata = d;
        exp_q.push_back(exp);
        due_q.push_back(cyc + 1);
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, p0;
        resetn = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
        force_en = 1'b0; force_val = '0;
        idle(3);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_pulses", 64'({start_p, stop_p}), 64'd0);
        resetn = 1'b1;
        idle(5);

        // Reset values of every register and an unmapped address.
        for (int a = 0; a < 5; a++) rd_reg(4'(a), 32'd0);
        rd_reg(4'd7, 32'd0);
        wr_reg(4'd9, 32'hFFFF_FFFF);
        rd_reg(4'd4, 32'd0);

        // Host start, 100 cycles, host stop.
        p0 = start_cnt; s0 = stop_cnt;
        wr_reg(4'd0, 32'h1);
        idle(5);
        rd_reg(4'd1, 32'h1);
        rd_reg(4'd0, 32'h1);
        idle(93);
        wr_reg(4'd0, 32'h2);
        idle(3);
        rd_reg(4'd1, 32'h0);
        rd_reg(4'd2, 32'd101);
        rd_reg(4'd3, 32'd0);
        rd_reg(4'd1, 32'h2);
        check("host_start_pulses", 64'(start_cnt - p0), 64'd1);
        check("host_stop_pulses", 64'(stop_cnt - s0), 64'd1);

        // Simultaneous read and write returns the old value.
        rdwr_reg(4'd4, 32'd1000, 32'd0);
        rd_reg(4'd4, 32'd1000);

        // Auto-stop window of 1000 cycles.
        p0 = start_cnt; s0 = stop_cnt;
        wr_reg(4'd0, 32'h1);
        for (int i = 0; i < 1100 && stop_cnt == s0; i++) idle(1);
        check("auto_stop_seen", 64'(stop_cnt - s0), 64'd1);
        check("auto_stop_dist", 64'(stop_cyc - start_cyc), 64'd1000);
        idle(3);
        rd_reg(4'd2, 32'd1000);
        rd_reg(4'd3, 32'd0);
        rd_reg(4'd1, 32'h6);
        wr_reg(4'd1, 32'h4);
        rd_reg(4'd1, 32'h2);

        // Coherent 64-bit snapshot.
        force_en = 1'b1; force_val = 64'h0000_0001_FFFF_FFFF;
        rd_reg(4'd2, 32'hFFFF_FFFF);
        force_val = 64'h0000_0002_0000_0000;
        rd_reg(4'd3, 32'h1);
        force_en = 1'b0;

        // CONTROL=3: stop only.
        p0 = start_cnt; s0 = stop_cnt;
        wr_reg(4'd0, 32'h3);
        idle(4);
        check("ctrl3_start", 64'(start_cnt - p0), 64'd0);
        check("ctrl3_stop", 64'(stop_cnt - s0), 64'd1);

        // Host stop cancels a 500-cycle window at +200.
        wr_reg(4'd4, 32'd500);
        p0 = start_cnt; s0 = stop_cnt;
        wr_reg(4'd0, 32'h1);
        idle(199);
        wr_reg(4'd0, 32'h2);
        idle(600);
        check("cancel_stops", 64'(stop_cnt - s0), 64'd1);
        check("cancel_dist", 64'(stop_cyc - start_cyc), 64'd200);
        rd_reg(4'd1, 32'h0);

        // N=1: stop right after start.
        wr_reg(4'd4, 32'd1);
        wr_reg(4'd0, 32'h1);
        idle(4);
        check("n1_dist", 64'(stop_cyc - start_cyc), 64'd1);
        rd_reg(4'd2, 32'd1);
        rd_reg(4'd1, 32'h6);

        // Reset mid-window: no stop ever, all registers cleared.
        wr_reg(4'd4, 32'd500);
        wr_reg(4'd0, 32'h1);
        idle(50);
        s0 = stop_cnt;
        resetn = 1'b0;
        idle(5);
        resetn = 1'b1;
        idle(600);
        check("rst_no_stop", 64'(stop_cnt - s0), 64'd0);
        rd_reg(4'd0, 32'd0);
        rd_reg(4'd1, 32'd0);
        rd_reg(4'd4, 32'd0);
        rd_reg(4'd3, 32'd0);
        rd_reg(4'd2, 32'd0);

        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("waitrequest_low", 64'(wreq_seen), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
